ensemble_vote_accumulator: RTL and testbench

Sequential vote-and-argmax stage that sits directly downstream of the final neuron layer of each ensemble member. It consumes one NUM_CLASSES-bit vector of 1-bit neuron outputs per member, serially over NUM_MEMBERS beats. It accumulates per-class vote counts, scans them for the winning class, and presents the classification result with a valid/ready handshake to the output interface.

---
 rtl/ensemble_vote_accumulator.sv | 170 +++++++++++++++++
 tb/tb_ensemble_vote_accumulator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ensemble_vote_accumulator.sv
// Accumulates per-class votes from NUM_MEMBERS serial member beats, then scans
// the counters one class per cycle to find the winner and hands it downstream.
module ensemble_vote_accumulator #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_MEMBERS = 4,
  parameter int CNT_W       = $clog2(NUM_MEMBERS + 1),
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CLASSES-1:0] in_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_class,
  output logic [CNT_W-1:0]       out_votes,
  output logic                   out_tie
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] LAST_MEMBER = CNT_W'(NUM_MEMBERS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_votes_q, best_votes_d;
  logic             tie_q, tie_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_class_q, out_class_d;
  logic [CNT_W-1:0] out_votes_q, out_votes_d;
  logic             out_tie_q, out_tie_d;

  logic [CNT_W-1:0] scan_cnt_s;

  assign scan_cnt_s = cnt_q[idx_q];

  // Next-state, counter update and scan comparison
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcnt_d       = mcnt_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_votes_d = best_votes_q;
    tie_d        = tie_q;

    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(in_bits[c]);
          end
          if (mcnt_q == LAST_MEMBER) begin
            mcnt_d  = '0;
            idx_d   = '0;
            state_d = ST_SCAN;
          end else begin
            mcnt_d = mcnt_q + CNT_W'(1);
          end
        end else begin
          mcnt_d = mcnt_q;
        end
      end
      ST_SCAN: begin
        if (idx_q == '0) begin
          best_idx_d   = '0;
          best_votes_d = scan_cnt_s;
          tie_d        = 1'b0;
        end else if (scan_cnt_s > best_votes_q) begin
          best_idx_d   = idx_q;
          best_votes_d = scan_cnt_s;
          tie_d        = 1'b0;
        end else if (scan_cnt_s == best_votes_q) begin
          // Equal count keeps the earlier (lower) index as winner
          tie_d = 1'b1;
        end else begin
          tie_d = tie_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt_d[c] = '0;
          end
          best_idx_d   = '0;
          best_votes_d = '0;
          tie_d        = 1'b0;
          state_d      = ST_ACCUM;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // Output registers follow the next state so they line up with state_q
  always_comb begin
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      out_class_d = best_idx_d;
      out_votes_d = best_votes_d;
      out_tie_d   = tie_d;
    end else begin
      out_class_d = '0;
      out_votes_d = '0;
      out_tie_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cnt_q[c] <= '0;
      end
      mcnt_q       <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_votes_q <= '0;
      tie_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_votes_q  <= '0;
      out_tie_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcnt_q       <= mcnt_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_votes_q <= best_votes_d;
      tie_q        <= tie_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_votes_q  <= out_votes_d;
      out_tie_q    <= out_tie_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_votes = out_votes_q;
  assign out_tie   = out_tie_q;

endmodule

// File: tb/tb_ensemble_vote_accumulator.sv
// Directed bench for ensemble_vote_accumulator: hand-computed winners, latency,
// backpressure stability and reset recovery.
module tb_ensemble_vote_accumulator;

  localparam int NC    = 10;
  localparam int NM    = 4;
  localparam int CNT_W = $clog2(NM + 1);
  localparam int IDX_W = $clog2(NC);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NC-1:0]    in_bits = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [IDX_W-1:0] out_class;
  logic [CNT_W-1:0] out_votes;
  logic             out_tie;

  int checks = 0;
  int errors = 0;
  int lat;

  ensemble_vote_accumulator #(
    .NUM_CLASSES(NC),
    .NUM_MEMBERS(NM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bits  (in_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_votes(out_votes),
    .out_tie  (out_tie)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [NC-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_bits  = b;
    check("in_ready_beat", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_sample(input logic [NC-1:0] b0, input logic [NC-1:0] b1,
                             input logic [NC-1:0] b2, input logic [NC-1:0] b3);
    send_beat(b0);
    send_beat(b1);
    send_beat(b2);
    send_beat(b3);
  endtask

  // Counts cycles after the last accepted beat until out_valid; optionally
  // drives junk on in_valid/in_bits meanwhile, which must be ignored.
  task automatic wait_result(input bit noise, output int latency);
    @(negedge clk);
    latency  = 1;
    in_valid = noise;
    in_bits  = noise ? 10'h3FF : 10'h000;
    check("in_ready_scan", 32'(in_ready), 32'd0);
    check("out_valid_scan", 32'(out_valid), 32'd0);
    while (!out_valid && latency < 40) begin
      @(negedge clk);
      latency++;
    end
    in_valid = 1'b0;
    in_bits  = 10'h000;
    check("out_valid_rise", 32'(out_valid), 32'd1);
    check("latency", 32'(latency), 32'd11);
  endtask

  task automatic expect_result(input int cls, input int votes, input bit tie);
    check("out_class", 32'(out_class), 32'(cls));
    check("out_votes", 32'(out_votes), 32'(votes));
    check("out_tie", 32'(out_tie), 32'(tie));
  endtask

  task automatic handshake_then_idle();
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_votes", 32'(out_votes), 32'd0);
    check("rst_out_tie", 32'(out_tie), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Clear winner, with junk input during scan
    send_sample(10'h008, 10'h008, 10'h00C, 10'h001);
    wait_result(1'b1, lat);
    expect_result(3, 3, 1'b0);
    handshake_then_idle();

    // Tie between classes 1 and 5
    send_sample(10'h022, 10'h022, 10'h000, 10'h000);
    wait_result(1'b0, lat);
    expect_result(1, 2, 1'b1);
    handshake_then_idle();

    // All-zero votes
    send_sample(10'h000, 10'h000, 10'h000, 10'h000);
    wait_result(1'b0, lat);
    expect_result(0, 0, 1'b1);
    handshake_then_idle();

    // All-ones: counter maximum
    send_sample(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    wait_result(1'b0, lat);
    expect_result(0, 4, 1'b1);
    handshake_then_idle();

    // Backpressure for 20 cycles
    out_ready = 1'b0;
    send_sample(10'h100, 10'h100, 10'h180, 10'h010);
    wait_result(1'b0, lat);
    expect_result(8, 3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      expect_result(8, 3, 1'b0);
    end
    handshake_then_idle();

    // Second sample scores independently
    send_sample(10'h004, 10'h004, 10'h000, 10'h002);
    wait_result(1'b0, lat);
    expect_result(2, 2, 1'b0);
    handshake_then_idle();

    // Reset after two beats
    send_beat(10'h3FF);
    send_beat(10'h3FF);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    expect_result(0, 0, 1'b0);
    send_sample(10'h200, 10'h200, 10'h200, 10'h200);
    wait_result(1'b0, lat);
    expect_result(9, 4, 1'b0);
    handshake_then_idle();

    // Reset during scan
    send_sample(10'h001, 10'h001, 10'h001, 10'h001);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_scan_out_valid", 32'(out_valid), 32'd0);
    check("rst_scan_in_ready", 32'(in_ready), 32'd1);
    expect_result(0, 0, 1'b0);
    send_sample(10'h200, 10'h200, 10'h200, 10'h200);
    wait_result(1'b0, lat);
    expect_result(9, 4, 1'b0);
    handshake_then_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
